ula_decode_queue: RTL and testbench
===================================

Name: ula_decode_queue

Overview:
- Parametrised successor to the single-cycle opcode decoder in the multiprocessed architecture.
- Accepts opcodes with two operands over a valid/ready handshake and decodes each opcode to a ULA operation code.
- Tags each operation as single- or multi-cycle and buffers decoded entries in a DEPTH-entry FIFO.
- Issues entries to the ULA over a second valid/ready handshake, and counts illegal opcodes.

Parameters:
- OPCODE_W, 8, opcode width in bits; must be >= 4.
- OP_W, 4, ULA operation code width; must be >= 4.
- DATA_W, 8, width of each operand passed through with the opcode.
- DEPTH, 4, FIFO entries; must be a power of two and >= 2.
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  queue can accept an entry.
- in_opcode  in  OPCODE_W  raw opcode.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- out_valid  out  1  decoded entry available at the head.
- out_ready  in  1  ULA accepts the head entry.
- ula_operation  out  OP_W  decoded operation code.
- out_a  out  DATA_W  operand A of the head entry.
- out_b  out  DATA_W  operand B of the head entry.
- multi_cycle  out  1  head is MUL, DIV or MOD.
- illegal  out  1  head came from an illegal opcode.
- level  out  $clog2(DEPTH)+1  current number of entries.
- ill_count  out  ILL_CNT_W  illegal opcodes accepted since reset.

Behaviour:
- Decode table:
  - Opcodes 1..12 map to operation codes 1..12, zero-extended to OP_W: ADD=1, SUB=2, MUL=3, DIV=4, MOD=5, AND=6, OR=7, XOR=8, NOT=9, NOR=10, NAND=11, XNOR=12.
  - Every other opcode, including 0 and any value with bits above bit 3 set, is illegal: operation=0, illegal=1.
  - multi_cycle=1 only for operation codes 3, 4 and 5.
- Decode is performed on accept; the FIFO stores the decoded fields, not the raw opcode.
- Push occurs when in_valid && in_ready. in_ready = (level != DEPTH) and has no combinational dependence on out_ready.
- Pop occurs when out_valid && out_ready. out_valid = (level != 0).
- The head fields (ula_operation, out_a, out_b, multi_cycle, illegal) are driven from the storage array at the read pointer. When out_valid=0, all head fields are 0.
- Latency: an entry pushed at edge N is visible at out_valid after edge N (one cycle). There is no bypass.
- Simultaneous push and pop with 0 < level < DEPTH: both take effect and level is unchanged.
- Full (level=DEPTH): in_ready=0, so no push occurs; a pop that cycle frees a slot and in_ready=1 next cycle.
- Empty: out_valid=0 and out_ready is ignored.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Inputs may change freely while in_valid=0. An upstream that holds in_valid=1 must keep its data stable until the entry is accepted.
- ill_count increments on each pushed illegal entry and saturates at 2^ILL_CNT_W-1.
- Reset (synchronous, any time including mid-transfer):
  - pointers, level and ill_count clear to 0;
  - out_valid=0, in_ready=1, all head outputs 0;
  - a push or pop in the reset cycle is discarded;
  - storage contents need not be cleared.

Optional Feature:
- Macro: ULA_DECODE_TRAP_EN.
- When defined:
  - Illegal opcodes are accepted (in_ready rules unchanged) but never enqueued; level does not change.
  - ill_count still increments.
  - An extra output port, trap (1 bit), sets to 1 on the edge that accepts an illegal opcode, stays set until reset, and resets to 0.
  - The illegal head output is then constant 0.
- When undefined: illegal entries are enqueued with operation=0 and illegal=1 as described above, and the trap port does not exist.

Test Plan:
- Reset then idle: after reset=1 for 2 cycles -> in_ready=1, out_valid=0, level=0, ill_count=0, ula_operation=0.
- Decode sweep with out_ready=1: push opcodes 1..12 with in_a=8'hA5, in_b=8'h3C -> ula_operation equals the opcode 1..12 in order, each one cycle after push; multi_cycle=1 only for 3, 4 and 5; operands pass through unchanged.
- Fill and backpressure (DEPTH=4, out_ready=0): push opcodes 1, 2, 3, 4 -> level=4, in_ready=0, a fifth push is not accepted. Raise out_ready for one cycle -> pop yields operation 1, level=3, in_ready=1.
- Simultaneous push/pop at level=2, pushing opcode 8'h06 -> level stays 2; FIFO order preserved, with 6 emerging third.
- Illegal handling:
  - Macro undefined: push 8'h00, 8'h0D, 8'h81 -> three entries with illegal=1 and operation=0; ill_count=3.
  - Macro defined: same stimulus -> level=0, ill_count=3, trap=1.
  - Saturation with ILL_CNT_W=2: 5 illegal pushes -> ill_count=3.
- Reset mid-operation: at level=3, assert reset together with push and pop -> next cycle level=0, out_valid=0, ill_count=0; the subsequent push of opcode 2 emerges as operation 2.

Source files
------------

// File: rtl/ula_decode_queue_if.sv
// Upstream opcode and downstream ULA issue handshakes of the ULA decode queue,
// plus the level and illegal-count status fields.
interface ula_decode_queue_if #(
  parameter int unsigned OPCODE_W  = 8,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ILL_CNT_W = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [OPCODE_W-1:0]  in_opcode;
  logic [DATA_W-1:0]    in_a;
  logic [DATA_W-1:0]    in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [OP_W-1:0]      ula_operation;
  logic [DATA_W-1:0]    out_a;
  logic [DATA_W-1:0]    out_b;
  logic                 multi_cycle;
  logic                 illegal;
  logic [LVL_W-1:0]     level;
  logic [ILL_CNT_W-1:0] ill_count;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, ula_operation, out_a, out_b,
           multi_cycle, illegal, level, ill_count
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, ula_operation, out_a, out_b,
           multi_cycle, illegal, level, ill_count
  );
endinterface

// File: rtl/ula_decode_queue.sv
// Decodes opcodes into ULA operation codes and buffers them in a DEPTH-entry FIFO.
// Optional ULA_DECODE_TRAP_EN: illegal opcodes are dropped and raise a sticky trap.
module ula_decode_queue #(
  parameter int unsigned OPCODE_W  = 8,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  ula_decode_queue_if.slave  bus
`ifdef ULA_DECODE_TRAP_EN
  ,
  output logic               trap
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              multi;
    logic              ill;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [ILL_CNT_W-1:0] ill_q, ill_d;
  logic                 legal_c, push_c, pop_c, enq_c;
  entry_t               dec_c, head_c;

  // Decode on accept: only opcodes 1..12 are legal and map straight through.
  always_comb begin
    legal_c   = (bus.in_opcode != '0) && (bus.in_opcode <= OPCODE_W'(12));
    dec_c     = '0;
    dec_c.a   = bus.in_a;
    dec_c.b   = bus.in_b;
    dec_c.ill = !legal_c;
    if (legal_c) begin
      dec_c.op    = OP_W'(bus.in_opcode[3:0]);
      dec_c.multi = (bus.in_opcode[3:0] >= 4'd3) && (bus.in_opcode[3:0] <= 4'd5);
    end
  end

  assign bus.in_ready  = (level_q != LVL_W'(DEPTH));
  assign bus.out_valid = (level_q != '0);
  assign push_c        = bus.in_valid && bus.in_ready;
  assign pop_c         = bus.out_valid && bus.out_ready;

`ifdef ULA_DECODE_TRAP_EN
  assign enq_c = push_c && legal_c;
`else
  assign enq_c = push_c;
`endif

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ill_d   = ill_q;
    if (enq_c) wr_d = wr_q + PTR_W'(1);
    if (pop_c) rd_d = rd_q + PTR_W'(1);
    case ({enq_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Saturate rather than wrap so a flood of bad opcodes stays visible.
    if (push_c && !legal_c && (ill_q != '1)) ill_d = ill_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ill_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ill_q   <= ill_d;
    end
  end

  // Storage carries no reset; the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (enq_c && !reset) mem_q[wr_q] <= dec_c;
  end

  assign head_c = bus.out_valid ? mem_q[rd_q] : '0;

  assign bus.ula_operation = head_c.op;
  assign bus.out_a         = head_c.a;
  assign bus.out_b         = head_c.b;
  assign bus.multi_cycle   = head_c.multi;
  assign bus.level         = level_q;
  assign bus.ill_count     = ill_q;

`ifdef ULA_DECODE_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (push_c && !legal_c) trap_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= trap_d;
  end

  assign trap        = trap_q;
  assign bus.illegal = 1'b0;
`else
  assign bus.illegal = head_c.ill;
`endif
endmodule

// File: tb/tb_ula_decode_queue.sv
// Directed bench for ula_decode_queue with a queue-based reference model.
module tb_ula_decode_queue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ILL_MAX = 255;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  ula_decode_queue_if #(.OPCODE_W(8), .OP_W(4), .DATA_W(8), .DEPTH(DEPTH), .ILL_CNT_W(8)) bus ();

`ifdef ULA_DECODE_TRAP_EN
  logic trap;
  ula_decode_queue #(.OPCODE_W(8), .OP_W(4), .DATA_W(8), .DEPTH(DEPTH), .ILL_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .trap(trap)
  );
`else
  ula_decode_queue #(.OPCODE_W(8), .OP_W(4), .DATA_W(8), .DEPTH(DEPTH), .ILL_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  typedef struct {
    int       op;
    bit [7:0] a;
    bit [7:0] b;
    bit       mc;
    bit       il;
  } ent_t;

  ent_t q[$];
  int   mill  = 0;
  bit   mtrap = 1'b0;

  function automatic ent_t model_dec(input bit [7:0] opc, input bit [7:0] a, input bit [7:0] b);
    ent_t e;
    e.a = a;
    e.b = b;
    if (opc >= 1 && opc <= 12) begin
      e.op = int'(opc);
      e.il = 1'b0;
      e.mc = (opc == 3 || opc == 4 || opc == 5);
    end else begin
      e.op = 0;
      e.il = 1'b1;
      e.mc = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model advances on the same edge as the DUT.
  always @(posedge clk) begin
    bit   push_m, pop_m;
    ent_t e;
    if (reset) begin
      q.delete();
      mill  = 0;
      mtrap = 1'b0;
    end else begin
      push_m = (bus.in_valid === 1'b1) && (q.size() < DEPTH);
      pop_m  = (bus.out_ready === 1'b1) && (q.size() > 0);
      e      = model_dec(bus.in_opcode, bus.in_a, bus.in_b);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        if (e.il) begin
          if (mill < ILL_MAX) mill++;
        end
`ifdef ULA_DECODE_TRAP_EN
        if (e.il) mtrap = 1'b1;
        else q.push_back(e);
`else
        q.push_back(e);
`endif
      end
    end
  end

  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      n = q.size();
      chk("level", 32'(bus.level), 32'(n));
      chk("in_ready", 32'(bus.in_ready), 32'(n != DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
      chk("ill_count", 32'(bus.ill_count), 32'(mill));
      if (n > 0) begin
        chk("head_op", 32'(bus.ula_operation), 32'(q[0].op));
        chk("head_a", 32'(bus.out_a), 32'(q[0].a));
        chk("head_b", 32'(bus.out_b), 32'(q[0].b));
        chk("head_mc", 32'(bus.multi_cycle), 32'(q[0].mc));
        chk("head_ill", 32'(bus.illegal), 32'(q[0].il));
      end else begin
        chk("idle_head", {bus.ula_operation, bus.out_a, bus.out_b, bus.multi_cycle, bus.illegal}, 32'd0);
      end
`ifdef ULA_DECODE_TRAP_EN
      chk("trap", 32'(trap), 32'(mtrap));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [7:0] opc, input bit [7:0] a, input bit [7:0] b);
    bus.in_valid  = v;
    bus.in_opcode = opc;
    bus.in_a      = a;
    bus.in_b      = b;
  endtask

  logic [12:0] mc_tab;

  initial begin
    mc_tab = 13'b0000000111000;
    reset  = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_ill", 32'(bus.ill_count), 32'd0);
    chk("rst_op", 32'(bus.ula_operation), 32'd0);
    reset = 1'b0;
    step();

    // Decode sweep, draining every cycle.
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 8'(k), 8'hA5, 8'h3C);
      step();
      chk("sweep_op", 32'(bus.ula_operation), 32'(k));
      chk("sweep_mc", 32'(bus.multi_cycle), 32'(mc_tab[k]));
      chk("sweep_ab", {16'h0, bus.out_a, bus.out_b}, 32'h0000A53C);
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    step();
    chk("sweep_drained", 32'(bus.level), 32'd0);

    // Fill and backpressure.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 8'(k), 8'(k), 8'(8'h10 + k));
      step();
    end
    chk("full_level", 32'(bus.level), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 8'h05, 8'h55, 8'h66);
    step();
    chk("full_no_push", 32'(bus.level), 32'd4);
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    chk("full_head", 32'(bus.ula_operation), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pop_level", 32'(bus.level), 32'd3);
    chk("pop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("pop_next_head", 32'(bus.ula_operation), 32'd2);

    // Simultaneous push/pop at level 2.
    bus.out_ready = 1'b1;
    step();
    chk("lvl2", 32'(bus.level), 32'd2);
    drive(1'b1, 8'h06, 8'h77, 8'h88);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    chk("pp_level", 32'(bus.level), 32'd2);
    chk("pp_head", 32'(bus.ula_operation), 32'd4);
    bus.out_ready = 1'b1;
    step();
    chk("pp_third", 32'(bus.ula_operation), 32'd6);
    step();
    chk("pp_empty", 32'(bus.out_valid), 32'd0);

    // Illegal opcodes.
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h00, 8'h01, 8'h02);
    step();
    drive(1'b1, 8'h0D, 8'h03, 8'h04);
    step();
    drive(1'b1, 8'h81, 8'h05, 8'h06);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    chk("ill_count3", 32'(bus.ill_count), 32'd3);
`ifdef ULA_DECODE_TRAP_EN
    chk("trap_level", 32'(bus.level), 32'd0);
    chk("trap_set", 32'(trap), 32'd1);
`else
    chk("ill_level", 32'(bus.level), 32'd3);
    chk("ill_head", {bus.ula_operation, bus.illegal}, 32'h00000001);
`endif
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    bus.out_ready = 1'b0;

    // Reset mid-operation with push and pop pending.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 8'(k), 8'h11, 8'h22);
      step();
    end
    chk("pre_rst_level", 32'(bus.level), 32'd3);
    reset = 1'b1;
    drive(1'b1, 8'h07, 8'h33, 8'h44);
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    chk("mid_rst_level", 32'(bus.level), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ill", 32'(bus.ill_count), 32'd0);
    drive(1'b1, 8'h02, 8'h9A, 8'hBC);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    chk("post_rst_op", 32'(bus.ula_operation), 32'd2);

    // Saturate the illegal counter.
    bus.out_ready = 1'b1;
    drive(1'b1, 8'hFF, 8'h01, 8'h01);
    for (int k = 0; k < 262; k++) step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    chk("ill_sat", 32'(bus.ill_count), 32'd255);
    step();
    step();
    chk("ill_sat_hold", 32'(bus.ill_count), 32'd255);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
